// File: rtl/fu_issue_fifo_n_pkg.sv
// Shared types for the FU issue FIFO: the issue packet carried between the
// issue stage and one functional-unit class, plus the FIFO depth default.
package fu_issue_fifo_n_pkg;

  localparam int IS_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_MULT   = 2'd1,
    FU_LS     = 2'd2,
    FU_BRANCH = 2'd3
  } fu_class_e;

  typedef struct packed {
    logic        valid;
    fu_class_e   fu_class;
    logic [5:0]  rob_idx;
    logic [3:0]  func;
    logic [31:0] src1;
  } issue_fu_packet_t;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fu_issue_fifo_n_compact.sv
// Squeezes N sparse packets into a dense, port-ordered list and reports how
// many of them are live.
module pckt_compact
  import fu_issue_fifo_n_pkg::*;
#(
  parameter int N = 3
) (
  input  issue_fu_packet_t           pckt_in  [N],
  output issue_fu_packet_t           pckt_out [N],
  output logic [$clog2(N+1)-1:0]     num_valid
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int VW = $clog2(N + 1);

  always_comb begin
    int pos;
    // NOTE: every output gets a default before the loop; a path that leaves a
    // combinational output unassigned would infer a latch.
    pckt_out = '{default: '0};
    pos      = 0;
    for (int i = 0; i < N; i++) begin
      if (pckt_in[i].valid) begin
        pckt_out[IW'(pos)] = pckt_in[i];
        pos++;
      end
    end
    num_valid = VW'(pos);
  end

endmodule

// File: rtl/fu_issue_fifo_n.sv
// Multi-port issue FIFO for one FU class: NUM_IN sparse writes, NUM_OUT
// first-word-fall-through reads, squash, occupancy, almost-full and overflow.
module fu_issue_fifo_n
  import fu_issue_fifo_n_pkg::*;
#(
  parameter int NUM_IN    = 3,
  parameter int NUM_OUT   = 3,
  parameter int DEPTH     = IS_FIFO_DEPTH,
  parameter int AF_MARGIN = 2 * NUM_IN
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  issue_fu_packet_t             fu_pckt_in  [NUM_IN],
  input  logic [NUM_OUT-1:0]           rd_en,
  output issue_fu_packet_t             fu_pckt_out [NUM_OUT],
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         full,
  output logic                         overflow
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int NVW = $clog2(NUM_IN + 1);

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [DEPTH-1:0]  entry_valid;
  issue_fu_packet_t  mem [DEPTH];

  issue_fu_packet_t  dense [NUM_IN];
  logic [NVW-1:0]    num_valid;
  int                pops;
  int                pushes;
  logic              ovf_next;

  pckt_compact #(.N(NUM_IN)) u_compact (
    .pckt_in   (fu_pckt_in),
    .pckt_out  (dense),
    .num_valid (num_valid)
  );

  // Enabled ports take consecutive entries from head in ascending port order.
  always_comb begin
    int            m;
    logic [PW-1:0] idx;
    m    = 0;
    pops = 0;
    for (int j = 0; j < NUM_OUT; j++) begin
      fu_pckt_out[j] = '0;
      idx            = head + PW'(m);
      if (rd_en[j]) begin
        if (!squash && (m < int'(count)) && entry_valid[idx]) begin
          fu_pckt_out[j] = mem[idx];
          pops++;
        end
        m++;
      end
    end
  end

  // Same-cycle pops free space for this cycle's writes.
  always_comb begin
    int space;
    space    = DEPTH - int'(count) + pops;
    pushes   = squash ? 0 : min_int(int'(num_valid), space);
    ovf_next = !squash && (int'(num_valid) > space);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      entry_valid <= '0;
      overflow    <= 1'b0;
    end else if (squash) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      entry_valid <= '0;
      overflow    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every read in this block
      // sees the pre-edge value; later writes to the same bit win, which lets
      // a refill of a just-popped slot (full FIFO) override its clear.
      head     <= head + PW'(pops);
      tail     <= tail + PW'(pushes);
      count    <= CW'(int'(count) - pops + pushes);
      overflow <= ovf_next;
      for (int i = 0; i < NUM_OUT; i++)
        if (i < pops) entry_valid[head + PW'(i)] <= 1'b0;
      for (int k = 0; k < NUM_IN; k++)
        if (k < pushes) entry_valid[tail + PW'(k)] <= 1'b1;
    end
  end

  // NOTE: the payload array is deliberately not reset; entry_valid and count
  // gate every read, so stale payload is never visible.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_IN; k++)
      if (k < pushes) mem[tail + PW'(k)] <= dense[k];
  end

  assign almost_full = (DEPTH - int'(count)) <= AF_MARGIN;
  assign full        = (int'(count) == DEPTH);

endmodule

// File: tb/tb_fu_issue_fifo_n.sv
// Directed bench for fu_issue_fifo_n: a 3-in/3-out instance and a 3-in/1-out
// instance, both DEPTH=8 with an almost-full margin of 6.
module tb_fu_issue_fifo_n;
  import fu_issue_fifo_n_pkg::*;

  localparam int NI = 3;
  localparam int NO = 3;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic             squash;
  issue_fu_packet_t in_p  [NI];
  logic [NO-1:0]    rd_en;
  issue_fu_packet_t out_p [NO];
  logic [CW-1:0]    count;
  logic             almost_full, full, overflow;

  issue_fu_packet_t in1_p  [NI];
  logic [0:0]       rd1;
  issue_fu_packet_t out1_p [1];
  logic [CW-1:0]    count1;
  logic             af1, full1, ovf1;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clock = ~clock;

  fu_issue_fifo_n #(.NUM_IN(NI), .NUM_OUT(NO), .DEPTH(D), .AF_MARGIN(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .squash      (squash),
    .fu_pckt_in  (in_p),
    .rd_en       (rd_en),
    .fu_pckt_out (out_p),
    .count       (count),
    .almost_full (almost_full),
    .full        (full),
    .overflow    (overflow)
  );

  fu_issue_fifo_n #(.NUM_IN(NI), .NUM_OUT(1), .DEPTH(D), .AF_MARGIN(6)) dut1 (
    .clock       (clock),
    .reset       (reset),
    .squash      (squash),
    .fu_pckt_in  (in1_p),
    .rd_en       (rd1),
    .fu_pckt_out (out1_p),
    .count       (count1),
    .almost_full (af1),
    .full        (full1),
    .overflow    (ovf1)
  );

  function automatic issue_fu_packet_t pk(input int id);
    issue_fu_packet_t p;
    p = '0;
    if (id >= 0) begin
      p.valid    = 1'b1;
      p.fu_class = fu_class_e'(id[1:0]);
      p.rob_idx  = id[5:0];
      p.func     = id[3:0] ^ 4'h5;
      p.src1     = 32'(id * 1000 + 7);
    end
    return p;
  endfunction

  task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_p(input string tag, input issue_fu_packet_t obs, input issue_fu_packet_t exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int a, input int b, input int c);
    in_p[0] = pk(a);
    in_p[1] = pk(b);
    in_p[2] = pk(c);
  endtask

  task automatic exp_out(input string tag, input int e0, input int e1, input int e2);
    chk_p({tag, "_p0"}, out_p[0], pk(e0));
    chk_p({tag, "_p1"}, out_p[1], pk(e1));
    chk_p({tag, "_p2"}, out_p[2], pk(e2));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    squash = 1'b0;
    rd_en  = '1;
    rd1    = 1'b0;
    set_in(-1, -1, -1);
    for (int i = 0; i < NI; i++) in1_p[i] = '0;

    // Reset state
    #2;
    chk_v("rst_count", 32'(count), 0);
    chk_v("rst_af", 32'(almost_full), 0);
    chk_v("rst_full", 32'(full), 0);
    chk_v("rst_ovf", 32'(overflow), 0);
    exp_out("rst_out", -1, -1, -1);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Sparse order; empty FIFO with all ports enabled, no write-through
    set_in(1, -1, 2); rd_en = 3'b111; #1;
    exp_out("t2_empty", -1, -1, -1);
    chk_v("t2_cnt0", 32'(count), 0);
    tick();
    set_in(-1, 3, -1); rd_en = 3'b000; #1;
    chk_v("t2_cnt2", 32'(count), 2);
    tick();
    set_in(-1, -1, -1); rd_en = 3'b101; #1;
    chk_v("t2_cnt3", 32'(count), 3);
    exp_out("t2_rd1", 1, -1, 2);
    tick();
    chk_v("t2_cnt1", 32'(count), 1);
    exp_out("t2_rd2", 3, -1, -1);
    tick();
    chk_v("t2_cntz", 32'(count), 0);
    exp_out("t2_rd3", -1, -1, -1);

    // Wrap + full: steady 2-pop / 2-push on a full FIFO
    rd_en = 3'b000;
    set_in(10, 11, 12); tick();
    set_in(13, 14, 15); tick();
    set_in(16, 17, -1); tick();
    chk_v("t3_cnt8", 32'(count), 8);
    chk_v("t3_full", 32'(full), 1);
    chk_v("t3_af", 32'(almost_full), 1);
    for (int i = 0; i < 10; i++) begin
      set_in(18 + 2 * i, 19 + 2 * i, -1); rd_en = 3'b011; #1;
      exp_out("t3_ss", 10 + 2 * i, 11 + 2 * i, -1);
      chk_v("t3_ss_full", 32'(full), 1);
      tick();
      chk_v("t3_ss_ovf", 32'(overflow), 0);
      chk_v("t3_ss_cnt", 32'(count), 8);
    end
    set_in(-1, -1, -1); rd_en = 3'b111;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < NO; k++)
        chk_p("t3_drain", out_p[k], pk((30 + 3 * c + k <= 37) ? 30 + 3 * c + k : -1));
      tick();
    end
    chk_v("t3_empty", 32'(count), 0);

    // Overflow: count 7, three inputs, one pop -> third input dropped
    rd_en = 3'b000;
    set_in(40, 41, 42); tick();
    set_in(43, 44, 45); tick();
    set_in(46, -1, -1); tick();
    chk_v("t4_cnt7", 32'(count), 7);
    set_in(47, 48, 49); rd_en = 3'b001; #1;
    chk_p("t4_pop", out_p[0], pk(40));
    chk_v("t4_ovf_pre", 32'(overflow), 0);
    tick();
    chk_v("t4_cnt8", 32'(count), 8);
    chk_v("t4_ovf", 32'(overflow), 1);
    chk_v("t4_full", 32'(full), 1);
    set_in(-1, -1, -1); rd_en = 3'b000; tick();
    chk_v("t4_ovf_end", 32'(overflow), 0);
    chk_v("t4_cnt8b", 32'(count), 8);
    rd_en = 3'b111;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < NO; k++)
        chk_p("t4_drain", out_p[k], pk((41 + 3 * c + k <= 48) ? 41 + 3 * c + k : -1));
      tick();
    end
    chk_v("t4_empty", 32'(count), 0);

    // Squash with live inputs and all ports enabled
    rd_en = 3'b000;
    set_in(50, 51, 52); tick();
    set_in(53, 54, 55); tick();
    chk_v("t5_cnt6", 32'(count), 6);
    squash = 1'b1; set_in(56, 57, 58); rd_en = 3'b111; #1;
    exp_out("t5_sq", -1, -1, -1);
    tick();
    squash = 1'b0; set_in(-1, -1, -1); #1;
    chk_v("t5_cnt0", 32'(count), 0);
    chk_v("t5_ovf", 32'(overflow), 0);
    chk_v("t5_full", 32'(full), 0);
    exp_out("t5_after", -1, -1, -1);
    tick();
    set_in(60, -1, -1); rd_en = 3'b000; tick();
    set_in(-1, -1, -1); rd_en = 3'b111; #1;
    exp_out("t5_fresh", 60, -1, -1);
    tick();
    chk_v("t5_cnt_end", 32'(count), 0);

    // Async reset mid-traffic
    rd_en = 3'b000;
    set_in(70, 71, 72); tick();
    set_in(73, 74, -1); tick();
    set_in(-1, -1, -1);
    chk_v("t1_cnt5", 32'(count), 5);
    chk_v("t1_af", 32'(almost_full), 1);
    rd_en = 3'b111; #1;
    exp_out("t1_live", 70, 71, 72);
    #1 reset = 1'b0;
    #1;
    chk_v("t1_cnt", 32'(count), 0);
    chk_v("t1_af0", 32'(almost_full), 0);
    chk_v("t1_full0", 32'(full), 0);
    exp_out("t1_out", -1, -1, -1);
    @(negedge clock);
    reset = 1'b1; rd_en = 3'b000;
    tick();
    chk_v("t6_cnt0", 32'(count), 0);
    chk_v("t6_af_c0", 32'(almost_full), 0);

    // Almost-full threshold: free entries <= 6
    set_in(80, -1, -1); tick();
    chk_v("t6_cnt1", 32'(count), 1);
    chk_v("t6_af_c1", 32'(almost_full), 0);
    set_in(81, -1, -1); tick();
    chk_v("t6_cnt2", 32'(count), 2);
    chk_v("t6_af_c2", 32'(almost_full), 1);
    set_in(-1, -1, -1);

    // Single-read-port configuration
    in1_p[0] = pk(90); in1_p[1] = pk(91); in1_p[2] = pk(92);
    tick();
    for (int i = 0; i < NI; i++) in1_p[i] = '0;
    chk_v("t6n_cnt3", 32'(count1), 3);
    chk_v("t6n_af", 32'(af1), 1);
    rd1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_p("t6n_out", out1_p[0], pk(90 + k));
      chk_v("t6n_cnt", 32'(count1), 32'(3 - k));
      tick();
    end
    chk_p("t6n_empty", out1_p[0], pk(-1));
    chk_v("t6n_cnt_end", 32'(count1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
